// File: rtl/psg_pkg.sv
// Shared definitions for the PSG envelope block:
// FSM state encoding, shape-bit positions and the default prescale.
package psg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } env_state_e;

    localparam int SHP_CONT = 3;
    localparam int SHP_ATT  = 2;
    localparam int SHP_ALT  = 1;
    localparam int SHP_HOLD = 0;

    localparam int PRESCALE_DIV_DEF = 16;

endpackage

// File: rtl/tick_divider.sv
// Free-running power-of-two prescaler; tick_o is high while the
// count sits at DIV-1, and clear_i restarts the count from zero.
module tick_divider #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // DIV is a power of two, so the natural wrap of cnt_q is the modulus
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/envelope_generator.sv
// AY-style envelope generator: prescaled period counter driving a
// 16-step attack/decay sequencer with hold, alternate and continue.
module envelope_generator
    import psg_pkg::*;
#(
    parameter int PERIOD_BITS  = 16,
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [3:0]             shape,
    input  logic                   restart,
    output logic [3:0]             level,
    output logic                   holding,
    output logic                   step_strobe
);

    logic                   tick;
    logic [PERIOD_BITS-1:0] pcnt_q;
    logic [PERIOD_BITS-1:0] pcnt_d;
    logic [PERIOD_BITS-1:0] pcnt_inc;
    logic [PERIOD_BITS-1:0] per_eff;
    logic                   step_ev;

    env_state_e state_q;
    logic [3:0] step_q;
    logic       attack_q;
    logic [3:0] shape_q;
    logic [3:0] level_q;
    logic       holding_q;
    logic       strobe_q;
    logic       flip;

    tick_divider #(
        .DIV     (PRESCALE_DIV)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .clear_i (restart),
        .tick_o  (tick)
    );

    // The counter never exceeds period-1, so count+1 cannot overflow
    assign per_eff  = (period == '0) ? PERIOD_BITS'(1) : period;
    assign pcnt_inc = pcnt_q + 1'b1;
    assign step_ev  = tick && (pcnt_inc >= per_eff);
    assign flip     = attack_q ^ shape_q[SHP_ALT];

    always_comb begin
        pcnt_d = pcnt_q;
        if (restart) begin
            pcnt_d = '0;
        end else if (step_ev) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = pcnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= 4'd0;
            attack_q  <= 1'b0;
            shape_q   <= 4'd0;
            level_q   <= 4'd0;
            holding_q <= 1'b1;
            strobe_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (restart) begin
                state_q   <= RUN;
                step_q    <= 4'd0;
                attack_q  <= shape[SHP_ATT];
                shape_q   <= shape;
                level_q   <= shape[SHP_ATT] ? 4'd0 : 4'd15;
                holding_q <= 1'b0;
            end else if (state_q == RUN && step_ev) begin
                strobe_q <= 1'b1;
                if (step_q != 4'd15) begin
                    step_q  <= step_q + 4'd1;
                    level_q <= attack_q ? (step_q + 4'd1) : (4'd14 - step_q);
                end else if (!shape_q[SHP_CONT]) begin
                    state_q   <= HOLD;
                    level_q   <= 4'd0;
                    holding_q <= 1'b1;
                end else if (shape_q[SHP_HOLD]) begin
                    state_q   <= HOLD;
                    level_q   <= flip ? 4'd15 : 4'd0;
                    holding_q <= 1'b1;
                end else begin
                    step_q   <= 4'd0;
                    attack_q <= flip;
                    level_q  <= flip ? 4'd0 : 4'd15;
                end
            end
        end
    end

    assign level       = level_q;
    assign holding     = holding_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: expected steps are queued
// at restart and matched against each step_strobe by a monitor.
module tb_envelope_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] period;
    logic [3:0]  shape;
    logic        restart;
    logic [3:0]  level;
    logic        holding;
    logic        step_strobe;

    typedef struct {
        logic [3:0] lvl;
        logic       hold;
        int         t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   t0 = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    envelope_generator #(
        .PERIOD_BITS  (16),
        .PRESCALE_DIV (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .period      (period),
        .shape       (shape),
        .restart     (restart),
        .level       (level),
        .holding     (holding),
        .step_strobe (step_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step_strobe === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: strobe at cyc %0d level %0d, required none",
                         cyc, level);
            end else begin
                mon_e = sb.pop_front();
                if (level !== mon_e.lvl || holding !== mon_e.hold || cyc != mon_e.t) begin
                    n_fail++;
                    $display("FAIL step: got level %0d hold %0b cyc %0d, required level %0d hold %0b cyc %0d",
                             level, holding, cyc, mon_e.lvl, mon_e.hold, mon_e.t);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int lvl, input bit hold, input int t);
        exp_t e;
        e.lvl  = lvl[3:0];
        e.hold = hold;
        e.t    = t;
        sb.push_back(e);
    endtask

    // Called at a negedge; restart is sampled at the following posedge
    task automatic do_restart(input logic [3:0] sh, input logic [15:0] per);
        shape   = sh;
        period  = per;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        t0      = cyc;
    endtask

    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d steps missing after %0d cycles, required 0",
                     name, sb.size(), bound);
            sb.delete();
        end
    endtask

    initial begin
        reset   = 1'b1;
        restart = 1'b0;
        shape   = 4'd0;
        period  = 16'd1;
        repeat (3) @(negedge clk);
        check("rst_level", int'(level), 0);
        check("rst_holding", int'(holding), 1);
        check("rst_strobe", int'(step_strobe), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_level", int'(level), 0);
        check("idle_holding", int'(holding), 1);

        // Single decay then hold at 0
        do_restart(4'b0000, 16'd1);
        check("s0_init_level", int'(level), 15);
        check("s0_init_holding", int'(holding), 0);
        for (int k = 1; k <= 15; k++) push(15 - k, 1'b0, t0 + 16 * k);
        push(0, 1'b1, t0 + 256);
        drain(300, "s0_drain");
        repeat (48) @(negedge clk);
        check("s0_hold_level", int'(level), 0);
        check("s0_hold_holding", int'(holding), 1);

        // Attack then hold at 15
        do_restart(4'b1101, 16'd1);
        check("s13_init_level", int'(level), 0);
        for (int k = 1; k <= 15; k++) push(k, 1'b0, t0 + 16 * k);
        push(15, 1'b1, t0 + 256);
        drain(300, "s13_drain");
        repeat (48) @(negedge clk);
        check("s13_hold_level", int'(level), 15);
        check("s13_hold_holding", int'(holding), 1);

        // Triangle, period 2
        do_restart(4'b1010, 16'd2);
        check("s10_init_level", int'(level), 15);
        for (int k = 1; k <= 48; k++) begin
            if (k < 16)      push(15 - k, 1'b0, t0 + 32 * k);
            else if (k < 32) push(k - 16, 1'b0, t0 + 32 * k);
            else if (k < 48) push(47 - k, 1'b0, t0 + 32 * k);
            else             push(k - 48, 1'b0, t0 + 32 * k);
        end
        drain(1600, "s10_drain");

        // period 0, 1 and 3 with repeating decay
        do_restart(4'b1000, 16'd0);
        check("p0_init_level", int'(level), 15);
        for (int k = 1; k <= 4; k++) push(15 - k, 1'b0, t0 + 16 * k);
        drain(100, "p0_drain");
        do_restart(4'b1000, 16'd1);
        for (int k = 1; k <= 4; k++) push(15 - k, 1'b0, t0 + 16 * k);
        drain(100, "p1_drain");
        do_restart(4'b1000, 16'd3);
        for (int k = 1; k <= 3; k++) push(15 - k, 1'b0, t0 + 48 * k);
        drain(200, "p3_drain");

        // Restart landing on the cycle a step is due
        do_restart(4'b1000, 16'd1);
        push(14, 1'b0, t0 + 16);
        push(13, 1'b0, t0 + 32);
        drain(60, "coinc_pre_drain");
        while (cyc != t0 + 47) @(negedge clk);
        do_restart(4'b1100, 16'd1);
        check("coinc_no_strobe", int'(step_strobe), 0);
        check("coinc_level", int'(level), 0);
        push(1, 1'b0, t0 + 16);
        push(2, 1'b0, t0 + 32);
        drain(60, "coinc_post_drain");

        // Asynchronous reset mid-run at level 7
        do_restart(4'b0000, 16'd1);
        for (int k = 1; k <= 8; k++) push(15 - k, 1'b0, t0 + 16 * k);
        drain(200, "areset_pre_drain");
        check("areset_pre_level", int'(level), 7);
        #2;
        reset = 1'b1;
        #1;
        check("areset_level", int'(level), 0);
        check("areset_holding", int'(holding), 1);
        check("areset_strobe", int'(step_strobe), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (64) @(negedge clk);
        check("areset_idle_level", int'(level), 0);
        check("areset_idle_holding", int'(holding), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
